alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered ALU for the multicycle datapath. Accepts one operation per
//  valid/ready handshake and returns a registered result plus a persistent flag register
//  (Z, C, N, V). Adds SUB/SBB/XOR, signed overflow and carry chaining through the flag
//  register. An optional iterative multiplier occupies the unit for WIDTH cycles.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=4)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      unit can accept; transfer when in_valid & in_ready
//  op         in   3      operation code (alu_pkg::alu_op_t)
//  a, b       in   WIDTH  operands (unsigned or two's complement)
//  out_valid  out  1      one-cycle pulse: result/result_hi/flags just updated
//  result     out  WIDTH  low result word
//  result_hi  out  WIDTH  MUL high word; 0 for all other ops
//  flags      out  4      {Z,C,N,V}; holds between operations
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, result=0, result_hi=0, flags=0, FSM=IDLE. Reset during
//   MUL aborts it: no out_valid, and the next cycle is IDLE with in_ready=1.
//  Op codes: 000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 AND, 101 OR, 110 XOR, 111 MUL.
//  Carry-in: ADC uses the registered C; SBB subtracts the registered C (as borrow).
//  Arithmetic is computed at WIDTH+1 bits; result = low WIDTH bits.
//  Flags, updated only in the cycle out_valid is raised:
//   Z = (result==0); N = result[WIDTH-1].
//   ADD/ADC: C = carry out; V = signed overflow (operand signs equal, result sign differs).
//   SUB/SBB: C = borrow out (1 iff a < b+cin, unsigned);
//    V = signed overflow (operand signs differ, result sign differs from a).
//   AND/OR/XOR: C=0, V=0. MUL: C=V=(result_hi!=0); Z and N are taken from result only.
//  FSM states IDLE and MUL:
//   IDLE: in_ready=1. A non-MUL transfer registers its result; out_valid=1 on the
//    following cycle. Back-to-back transfers give one result per cycle.
//    A MUL transfer -> MUL state.
//   MUL: in_ready=0; unsigned shift-add, one bit per cycle, WIDTH cycles; in_valid is
//    ignored. After the last iteration, {result_hi,result} = a*b, out_valid pulses, and
//    the FSM returns to IDLE. Latency is WIDTH+1 cycles from acceptance to out_valid.
//  Operands are captured at acceptance; a/b/op may change afterwards without effect.
//  out_valid is never asserted without a preceding accepted transfer. No backpressure on
//   the output; the consumer must sample on the out_valid cycle.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL is implemented as above.
//  ALU_MUL_EN undefined: no multiplier logic and no MUL state. Op 111 completes as a
//   single-cycle op with result=0, result_hi=0, flags={Z=1,C=0,N=0,V=0}.
// STRUCTURE
//  alu_pkg: alu_op_t enum (3-bit codes above), flag bit indices FLAG_Z/C/N/V,
//   state enum (ST_IDLE, ST_MUL).
//  Sub-module alu_mul_iter (start, a, b -> done, prod[2*WIDTH-1:0]) holds the shift-add
//   datapath and iteration counter; it exists only under ALU_MUL_EN.
// TESTING (WIDTH=8)
//  1. ADD 0x7F+0x01 -> result=0x80, flags Z0 C0 N1 V1; out_valid 1 cycle after accept.
//  2. ADD 0xFF+0x01 -> 0x00, Z1 C1; then ADC 0x00+0x00 -> 0x01, C0.
//  3. SUB 0x03-0x05 -> 0xFE, C1 N1 V0; then SBB 0x10-0x00 -> 0x0F, C0.
//  4. MUL 0x10*0x20 -> result=0x00, result_hi=0x02, C1 V1 Z1; out_valid 9 cycles after
//     accept; in_ready=0 throughout; in_valid held high during MUL is not accepted.
//  5. MUL accepted, rst at 3rd busy cycle -> no out_valid, flags=0, in_ready=1 next cycle.
//  6. Ten back-to-back XOR ops, in_valid held high -> ten consecutive out_valid cycles,
//     with C=V=0 on each.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the registered multicycle ALU: op codes, flag bit positions, FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_ADC = 3'b001,
        OP_SUB = 3'b010,
        OP_SBB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    // Bit positions inside the {Z,C,N,V} flag word
    localparam int unsigned FLAG_Z    = 3;
    localparam int unsigned FLAG_C    = 2;
    localparam int unsigned FLAG_N    = 1;
    localparam int unsigned FLAG_V    = 0;
    localparam int unsigned NUM_FLAGS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// The first iteration is folded into the start cycle so done/prod are registered and
// land exactly WIDTH-1 cycles after start. Only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [PW-1:0]    src_c;
    logic [WIDTH-1:0] m_c;
    logic [WIDTH:0]   sum_c;
    logic [PW-1:0]    step_c;

    // One shift-add step on {hi, multiplier-remainder}; seeded from b when starting
    always_comb begin
        src_c  = start ? {{WIDTH{1'b0}}, b} : prod;
        m_c    = start ? a : mcand;
        sum_c  = {1'b0, src_c[PW-1:WIDTH]} + (src_c[0] ? {1'b0, m_c} : '0);
        step_c = {sum_c, src_c[WIDTH-1:1]};
    end

    // Iteration counter and product register; done pulses after the final step
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand <= a;
                prod  <= step_c;
                cnt   <= CW'(WIDTH - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                prod <= step_c;
                cnt  <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input handshake and a persistent {Z,C,N,V} flag register.
// Define ALU_MUL_EN to build the iterative multiplier (op 111 then takes WIDTH+1 cycles);
// without it op 111 completes in one cycle with a zero result and only Z set.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int unsigned EW  = WIDTH + 1;
    localparam int unsigned MSB = WIDTH - 1;

    state_t               state, state_next;
    alu_op_t              op_c;
    logic                 accept_c;
    logic                 is_mul_c;
    logic                 cin_c;
    logic [EW-1:0]        add_c, sub_c;
    logic [WIDTH-1:0]     alu_res_c;
    logic                 alu_cout_c, alu_ovf_c;
    logic                 ready_next, ov_next;
    logic [WIDTH-1:0]     res_next, hi_next;
    logic [NUM_FLAGS-1:0] flags_next;

    assign op_c     = alu_op_t'(op);
    assign accept_c = in_valid & in_ready;
    assign cin_c    = ((op_c == OP_ADC) || (op_c == OP_SBB)) ? flags[FLAG_C] : 1'b0;
    assign add_c    = {1'b0, a} + {1'b0, b} + EW'(cin_c);
    assign sub_c    = {1'b0, a} - {1'b0, b} - EW'(cin_c);

`ifdef ALU_MUL_EN
    logic                 mul_start_c;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    assign is_mul_c    = (op_c == OP_MUL);
    assign mul_start_c = accept_c & is_mul_c;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start_c),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`else
    assign is_mul_c = 1'b0;
`endif

    // Single-cycle datapath: result, carry/borrow and signed overflow for non-MUL ops
    always_comb begin
        alu_res_c  = '0;
        alu_cout_c = 1'b0;
        alu_ovf_c  = 1'b0;
        case (op_c)
            OP_ADD, OP_ADC: begin
                alu_res_c  = add_c[MSB:0];
                alu_cout_c = add_c[WIDTH];
                alu_ovf_c  = (a[MSB] == b[MSB]) && (add_c[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBB: begin
                alu_res_c  = sub_c[MSB:0];
                alu_cout_c = sub_c[WIDTH];
                alu_ovf_c  = (a[MSB] != b[MSB]) && (sub_c[MSB] != a[MSB]);
            end
            OP_AND:  alu_res_c = a & b;
            OP_OR:   alu_res_c = a | b;
            OP_XOR:  alu_res_c = a ^ b;
            default: ;
        endcase
    end

    // Next-state and next-output logic; outputs hold unless a result completes
    always_comb begin
        state_next = state;
        ov_next    = 1'b0;
        res_next   = result;
        hi_next    = result_hi;
        flags_next = flags;
        case (state)
            ST_IDLE: begin
                if (accept_c && is_mul_c) begin
                    state_next = ST_MUL;
                end else if (accept_c) begin
                    ov_next            = 1'b1;
                    res_next           = alu_res_c;
                    hi_next            = '0;
                    flags_next[FLAG_Z] = (alu_res_c == '0);
                    flags_next[FLAG_C] = alu_cout_c;
                    flags_next[FLAG_N] = alu_res_c[MSB];
                    flags_next[FLAG_V] = alu_ovf_c;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_next         = ST_IDLE;
                    ov_next            = 1'b1;
                    res_next           = mul_prod[MSB:0];
                    hi_next            = mul_prod[2*WIDTH-1:WIDTH];
                    flags_next[FLAG_Z] = (mul_prod[MSB:0] == '0);
                    flags_next[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                    flags_next[FLAG_N] = mul_prod[MSB];
                    flags_next[FLAG_V] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
        ready_next = (state_next == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= ready_next;
            out_valid <= ov_next;
            result    <= res_next;
            result_hi <= hi_next;
            flags     <= flags_next;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized op streams,
// compared against an integer-arithmetic reference model and an in-order expectation queue.
module tb_alu_seq;

    localparam int W   = 8;
    localparam int M   = 1 << W;
    localparam int TMO = 4 * W + 10;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   fl;
        int           acc_cyc;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    logic mz = 1'b0, mc = 1'b0, mn = 1'b0, mv = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the op definitions, tracking flags
    function automatic exp_t model(input int opi, input int ai, input int bi);
        exp_t e;
        int   cin, full, sa, sb, sr, p;
        cin = (opi == 1 || opi == 3) ? int'(mc) : 0;
        sa  = (ai >= M / 2) ? ai - M : ai;
        sb  = (bi >= M / 2) ? bi - M : bi;
        e.hi  = '0;
        e.lat = 1;
        e.acc_cyc = 0;
        case (opi)
            0, 1: begin
                full  = ai + bi + cin;
                e.res = W'(full);
                mc    = (full >= M);
                sr    = sa + sb + cin;
                mv    = (sr >= M / 2) || (sr < -(M / 2));
            end
            2, 3: begin
                full  = ai - bi - cin;
                e.res = W'(full);
                mc    = (ai < bi + cin);
                sr    = sa - sb - cin;
                mv    = (sr >= M / 2) || (sr < -(M / 2));
            end
            4: begin e.res = W'(ai & bi); mc = 1'b0; mv = 1'b0; end
            5: begin e.res = W'(ai | bi); mc = 1'b0; mv = 1'b0; end
            6: begin e.res = W'(ai ^ bi); mc = 1'b0; mv = 1'b0; end
            default: begin
`ifdef ALU_MUL_EN
                p     = ai * bi;
                e.res = W'(p % M);
                e.hi  = W'(p / M);
                mc    = (p / M) != 0;
                mv    = (p / M) != 0;
                e.lat = W + 1;
`else
                p     = 0;
                e.res = '0;
                mc    = 1'b0;
                mv    = 1'b0;
`endif
            end
        endcase
        mz   = (e.res == '0);
        mn   = e.res[W-1];
        e.fl = {mz, mc, mn, mv};
        return e;
    endfunction

    // Present one op and hold it until accepted; returns cycles spent waiting on in_ready
    task automatic send(input int opi, input int ai, input int bi, output int waited);
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        op       = 3'(opi);
        a        = W'(ai);
        b        = W'(bi);
        while (!in_ready && waited < TMO) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(opi, ai, bi);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Output monitor: every out_valid must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("result_hi", 32'(result_hi), 32'(e.hi));
                    check("flags", 32'(flags), 32'(e.fl));
                    check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, k;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_hi", 32'(result_hi), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        idle(1);

        // Overflow, carry chaining and borrow chaining
        send(0, 'h7F, 'h01, w);
        send(0, 'hFF, 'h01, w);
        send(1, 'h00, 'h00, w);
        send(2, 'h03, 'h05, w);
        send(3, 'h10, 'h00, w);
        idle(2);

        // Ten back-to-back XORs
        for (int i = 0; i < 10; i++) send(6, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), w);
        idle(2);

`ifdef ALU_MUL_EN
        // MUL with in_valid held high during the busy window
        send(7, 'h10, 'h20, w);
        send(0, 'h01, 'h02, w);
        check("mul_busy_cycles", 32'(w), 32'(W));
        idle(W + 3);

        // Reset in the third busy cycle aborts the multiply
        send(7, 'hC3, 'h5A, w);
        idle(2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        {mz, mc, mn, mv} = 4'b0000;
        idle(W + 3);
`else
        send(7, 'hAB, 'hCD, w);
        check("mul_off_no_wait", 32'(w), 32'd0);
        idle(2);
`endif

        // Randomized stream with mixed back-to-back and gapped ops
        for (int i = 0; i < 300; i++) begin
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), w);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
        in_valid = 1'b0;

        k = 0;
        while (exp_q.size() != 0 && k < 2 * W + 4) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
